// File: rtl/avalon_aes_channels.sv
// Avalon-MM register bank for N_CH AES channels, each with key/msg/result regs and START/DONE FSM.
// Optional macro AES_IRQ_EN adds a per-channel interrupt enable (reg 12 bit0) and the avl_irq output.
module avalon_aes_channels #(
    parameter int DATA_W    = 32,
    parameter int N_CH      = 2,
    parameter int EXPORT_CH = 0,
    parameter int ADDR_W    = ($clog2(N_CH * 16) < 4) ? 4 : $clog2(N_CH * 16)
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       avl_chipselect,
    input  logic                       avl_read,
    input  logic                       avl_write,
    input  logic [ADDR_W-1:0]          avl_address,
    input  logic [DATA_W/8-1:0]        avl_byteenable,
    input  logic [DATA_W-1:0]          avl_writedata,
    output logic [DATA_W-1:0]          avl_readdata,
    output logic [N_CH-1:0]            aes_start,
    output logic [N_CH*4*DATA_W-1:0]   aes_key,
    output logic [N_CH*4*DATA_W-1:0]   aes_msg,
    input  logic [N_CH-1:0]            aes_done,
    input  logic [N_CH*4*DATA_W-1:0]   aes_result,
    output logic [DATA_W-1:0]          aes_export_export_data
`ifdef AES_IRQ_EN
    ,
    output logic                       avl_irq
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [DATA_W-1:0] key_q    [N_CH][4];
    logic [DATA_W-1:0] msg_q    [N_CH][4];
    logic [DATA_W-1:0] result_q [N_CH][4];
    logic [N_CH-1:0]   start_q;
    logic [N_CH-1:0]   done_q;
    state_e            state_q  [N_CH];
    logic [N_CH-1:0]   aes_start_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] export_q;
`ifdef AES_IRQ_EN
    logic [N_CH-1:0]   ie_q;
    logic              irq_q;
`endif

    logic [ADDR_W-1:0] ch_sel;
    logic [3:0]        reg_sel;
    logic [N_CH-1:0]   wr_ch;
    logic              rd_en;
    logic              start_wr;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0]   old_v,
                                                      input logic [DATA_W-1:0]   new_v,
                                                      input logic [DATA_W/8-1:0] be);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign ch_sel   = avl_address >> 4;
    assign reg_sel  = avl_address[3:0];
    assign rd_en    = avl_chipselect && avl_read;
    assign start_wr = (reg_sel == 4'd14) && avl_byteenable[0];

    always_comb begin
        wr_ch   = '0;
        rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_sel == ADDR_W'(c)) begin
                wr_ch[c] = avl_chipselect && avl_write;
                case (reg_sel)
                    4'd0, 4'd1, 4'd2, 4'd3:     rd_data = key_q[c][reg_sel[1:0]];
                    4'd4, 4'd5, 4'd6, 4'd7:     rd_data = msg_q[c][reg_sel[1:0]];
                    4'd8, 4'd9, 4'd10, 4'd11:   rd_data = result_q[c][reg_sel[1:0]];
`ifdef AES_IRQ_EN
                    4'd12:                      rd_data = {{(DATA_W-1){1'b0}}, ie_q[c]};
`endif
                    4'd14:                      rd_data = {{(DATA_W-1){1'b0}}, start_q[c]};
                    4'd15:                      rd_data = {{(DATA_W-1){1'b0}}, done_q[c]};
                    default:                    rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int w = 0; w < 4; w++) begin
                    key_q[c][w]    <= '0;
                    msg_q[c][w]    <= '0;
                    result_q[c][w] <= '0;
                end
                state_q[c] <= StIdle;
            end
            start_q     <= '0;
            done_q      <= '0;
            aes_start_q <= '0;
            readdata_q  <= '0;
            export_q    <= '0;
`ifdef AES_IRQ_EN
            ie_q        <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            // Mux uses current register values, so a same-cycle write is not visible.
            if (rd_en) readdata_q <= rd_data;
            export_q <= key_q[EXPORT_CH][0];
`ifdef AES_IRQ_EN
            irq_q <= |(done_q & ie_q);
`endif
            for (int c = 0; c < N_CH; c++) begin
                aes_start_q[c] <= 1'b0;
`ifdef AES_IRQ_EN
                if (wr_ch[c] && reg_sel == 4'd12 && avl_byteenable[0])
                    ie_q[c] <= avl_writedata[0];
`endif
                // KEY and MSG are frozen only while the engine is running.
                if (wr_ch[c] && state_q[c] != StRun && !reg_sel[3]) begin
                    if (!reg_sel[2])
                        key_q[c][reg_sel[1:0]] <= merge_bytes(key_q[c][reg_sel[1:0]],
                                                              avl_writedata, avl_byteenable);
                    else
                        msg_q[c][reg_sel[1:0]] <= merge_bytes(msg_q[c][reg_sel[1:0]],
                                                              avl_writedata, avl_byteenable);
                end
                case (state_q[c])
                    StIdle, StDone: begin
                        if (wr_ch[c] && start_wr) begin
                            done_q[c] <= 1'b0;
                            if (avl_writedata[0]) begin
                                start_q[c]     <= 1'b1;
                                aes_start_q[c] <= 1'b1;
                                state_q[c]     <= StRun;
                            end else begin
                                start_q[c] <= 1'b0;
                                state_q[c] <= StIdle;
                            end
                        end
                    end
                    StRun: begin
                        if (aes_done[c]) begin
                            for (int w = 0; w < 4; w++)
                                result_q[c][w] <= aes_result[(c*4+w)*DATA_W +: DATA_W];
                            done_q[c]  <= 1'b1;
                            state_q[c] <= StDone;
                        end
                    end
                    default: state_q[c] <= StIdle;
                endcase
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        for (genvar w = 0; w < 4; w++) begin : g_word
            assign aes_key[(c*4+w)*DATA_W +: DATA_W] = key_q[c][w];
            assign aes_msg[(c*4+w)*DATA_W +: DATA_W] = msg_q[c][w];
        end
    end

    assign avl_readdata           = readdata_q;
    assign aes_start              = aes_start_q;
    assign aes_export_export_data = export_q;
`ifdef AES_IRQ_EN
    assign avl_irq                = irq_q;
`endif

endmodule

// File: doc/avalon_aes_channels.md
Name: avalon_aes_channels

Overview:
- Parametrised Avalon-MM slave register bank for 1..N_CH independent AES channels. Successor to the single-channel AES export interface.
- Each channel holds:
  - a 128-bit key;
  - a 128-bit message;
  - a 128-bit result;
  - a START/DONE handshake with an external AES engine.
- Sits between the Nios II Avalon fabric and the AES engine(s). Drives aes_export_export_data for the board hex display.

Parameters:
- DATA_W, 32, register width in bits; key/msg/result are 4*DATA_W each.
- N_CH, 2, number of channels, 1..4.
- EXPORT_CH, 0, channel whose key word 0 drives aes_export_export_data.
- ADDR_W, $clog2(N_CH*16) (minimum 4), Avalon word-address width; address = {channel, reg[3:0]}.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avl_chipselect  in  1  slave select.
- avl_read  in  1  read strobe.
- avl_write  in  1  write strobe.
- avl_address  in  ADDR_W  word address.
- avl_byteenable  in  DATA_W/8  write byte lanes.
- avl_writedata  in  DATA_W  write data.
- avl_readdata  out  DATA_W  read data, fixed latency 1.
- aes_start  out  N_CH  per-channel one-cycle start pulse.
- aes_key  out  N_CH*4*DATA_W  per-channel key, word 0 in LSBs.
- aes_msg  out  N_CH*4*DATA_W  per-channel message.
- aes_done  in  N_CH  per-channel one-cycle completion pulse.
- aes_result  in  N_CH*4*DATA_W  per-channel result; valid when aes_done is high.
- aes_export_export_data  out  DATA_W  registered export word.

Behaviour:
- Reset:
  - The clock is clk_clk. Reset is reset_reset_n, asynchronous and active-low.
  - On reset, all registers, avl_readdata, aes_start and aes_export_export_data go to 0, and every channel FSM goes to IDLE.
- Register map (per channel):
  - 0-3: KEY, R/W.
  - 4-7: MSG, R/W.
  - 8-11: RESULT, read-only.
  - 12-13: reserved (read 0, writes ignored).
  - 14: START, bit0, R/W.
  - 15: DONE, bit0, read-only.
  - Addresses for channel index >= N_CH read 0 and ignore writes.
- Writes:
  - Take effect when avl_chipselect and avl_write are both high.
  - Byte lanes are gated by avl_byteenable.
  - The register updates at the clock edge.
- Reads:
  - When avl_chipselect and avl_read are both high at edge N, avl_readdata holds the addressed register at edge N+1.
  - avl_readdata holds its value otherwise.
  - Read and write together: the read returns the pre-write value.
- FSM per channel, states IDLE, RUN, DONE:
  - IDLE:
    - A write of START bit0=1 sets START=1, DONE=0 and pulses aes_start for exactly 1 cycle (the cycle after the write edge). Next state is RUN.
    - aes_done is ignored.
  - RUN:
    - Writes to KEY, MSG and START are ignored.
    - On aes_done=1: RESULT<=aes_result and DONE=1. Next state is DONE.
  - DONE:
    - Write START=0: START=0, DONE=0, next state IDLE. RESULT is retained.
    - Write START=1: restart, with the same behaviour as START=1 from IDLE.
    - aes_done is ignored.
- Simultaneous events:
  - aes_done together with a START write in RUN: done wins and the write is dropped.
  - A write to a different channel never affects this channel.
- aes_key and aes_msg are driven directly from the registers; aes_start is registered.
- aes_export_export_data is registered, equal to channel EXPORT_CH KEY word 0 delayed 1 cycle.
- Mid-operation reset: the FSM returns to IDLE, and a later aes_done is ignored until the next START.

Optional Feature:
- Macro AES_IRQ_EN.
- Defined:
  - Reserved register 12 bit0 becomes the channel interrupt enable IE, R/W, reset 0.
  - Adds output port avl_irq (1 bit, registered).
  - avl_irq is high while any channel has DONE=1 and IE=1.
  - avl_irq clears one cycle after DONE or IE clears.
- Undefined: no avl_irq port, and register 12 reads 0.

Test Plan:
- Reset, then read ch0 reg 0: avl_readdata=0x00000000 one cycle after the read; aes_export_export_data=0.
- Write ch0 KEY0=0xDEADBEEF, byteenable=4'b0011, over a prior value of 0x11223344: read returns 0x1122BEEF. Export equals 0x1122BEEF, 1 cycle after the register updates.
- Write ch1 START=1: aes_start=2'b10 for exactly 1 cycle. Drive aes_done[1] with result words 0x0,0x1,0x2,0x3 → ch1 regs 8-11 read 0x0..0x3 and DONE reads 1. A MSG write during RUN leaves MSG unchanged.
- Channel isolation: ch0 in RUN, then write ch1 START=1 and write ch1 regs 8-11 (ignored). ch0 state is unchanged; a pulse on aes_done[0] alone completes only ch0.
- Same-cycle aes_done[0] and a ch0 START=0 write in RUN: DONE=1, START stays 1, state DONE. A following START=0 write then reads DONE=0.
- AES_IRQ_EN defined: IE=1, complete ch0 → avl_irq=1. Write START=0 → avl_irq=0 within 2 cycles. Assert reset mid-RUN → all outputs 0.
